// File: rtl/seq_mult_8.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_8
// Purpose  : N-bit unsigned shift-and-add multiplier. It takes one multiplier
//            bit per RUN cycle and produces a 2N-bit product.
// Options  : SEQ_MULT_EARLY_EXIT_EN - leave RUN as soon as no multiplier bits
//            remain.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_8 #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic [2*N-1:0]   PRODUCT,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [2*N-1:0]     mcand_q;
    logic [2*N-1:0]     acc_q;
    logic [2*N-1:0]     product_q;
    logic [N-1:0]       mult_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;

    logic [2*N-1:0]     addend_d;
    logic [2*N-1:0]     sum_d;
    logic               carry_d;
    logic               early_d;

    // Ripple-carry accumulate. The product fits in 2N bits, so the carry-out is never set.
    always_comb begin
        addend_d = mult_q[0] ? mcand_q : '0;
        sum_d    = '0;
        carry_d  = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            sum_d[i] = acc_q[i] ^ addend_d[i] ^ carry_d;
            carry_d  = (acc_q[i] & addend_d[i]) | (carry_d & (acc_q[i] ^ addend_d[i]));
        end
    end

    always_comb begin
`ifdef SEQ_MULT_EARLY_EXIT_EN
        early_d = (mult_q == '0);
`else
        early_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            mult_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mcand_q <= {{N{1'b0}}, A};
                        mult_q  <= B;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (early_d) begin
                        product_q <= acc_q;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        acc_q   <= sum_d;
                        mcand_q <= mcand_q << 1;
                        mult_q  <= mult_q >> 1;
                        cnt_q   <= cnt_q + 1'b1;
                        // The last step still adds, so the product is taken from the adder output.
                        if (cnt_q == C_CNT_LAST) begin
                            product_q <= sum_d;
                            done_q    <= 1'b1;
                            state_q   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign PRODUCT = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_8
// Purpose  : Scoreboard bench for seq_mult_8. It uses directed operands with
//            hand-computed products and done latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_8;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic [15:0] PRODUCT;
    logic        busy;
    logic        done;

    seq_mult_8 #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .PRODUCT(PRODUCT), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] prod;
        int          lat;
        int          t0;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   ndone = 0;
    int   npush = 0;
    int   last_done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            ndone++;
            last_done_cyc = cyc;
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("product", {16'd0, PRODUCT}, {16'd0, e.prod});
                chk("latency", cyc - e.t0 + 1, e.lat);
            end
        end
    end

    // Issue one multiply. It waits either for idle, or for done and then starts in the first IDLE cycle.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                         input int lat_def, input int lat_ee, input bit push, input bit b2b);
        int n;
        exp_t e;
        n = 0;
        if (b2b) begin
            do begin
                @(negedge clk);
                n++;
            end while (done !== 1'b1 && n < 40);
            if (n >= 40) chk("wait_done_timeout", 32'd1, 32'd0);
            @(negedge clk);
        end else begin
            @(negedge clk);
            while (busy !== 1'b0 && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) chk("wait_idle_timeout", 32'd1, 32'd0);
        end
        start = 1'b1;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = ~a;
        B = ~b;
        if (push) begin
            e.prod = p;
            e.lat  = EE ? lat_ee : lat_def;
            e.t0   = cyc;
            q.push_back(e);
            npush++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int  nbusy;
        bit  prod_moved;
        int  d0;
        int  nd_before;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_product", {16'd0, PRODUCT}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Largest operands; also count busy cycles and check that PRODUCT holds during RUN.
        issue(8'hFF, 8'hFF, 16'hFE01, 9, 9, 1'b1, 1'b0);
        nbusy = 0;
        prod_moved = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            nbusy++;
            if (done !== 1'b1 && PRODUCT !== 16'h0000) prod_moved = 1'b1;
        end
        chk("busy_cycles", nbusy, 9);
        chk("product_stable_in_run", {31'd0, prod_moved}, 32'd0);

        // Back-to-back pair: the done pulses are spaced by the second latency plus one.
        issue(8'h0D, 8'h0B, 16'h008F, 9, 6, 1'b1, 1'b0);
        issue(8'h00, 8'h5A, 16'h0000, 9, 9, 1'b1, 1'b1);
        d0 = cyc;
        wait_idle();
        chk("b2b_done_spacing", last_done_cyc - (d0 - 1), 32'd9);

        // A start in RUN is ignored, and the operands in progress are unaffected.
        issue(8'h12, 8'h34, 16'h03A8, 9, 8, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        A = 8'hFF;
        B = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset in the middle of RUN aborts the operation without a done pulse.
        issue(8'hFF, 8'hFF, 16'h0000, 9, 9, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_product", {16'd0, PRODUCT}, 32'd0);
        rst = 1'b0;
        nd_before = ndone;
        repeat (15) @(negedge clk);
        chk("no_done_after_abort", ndone, nd_before);

        // Short multipliers (these exit early only when that option is built in) and further directed cases.
        issue(8'h77, 8'h00, 16'h0000, 9, 2, 1'b1, 1'b0);
        issue(8'h77, 8'h01, 16'h0077, 9, 3, 1'b1, 1'b0);
        issue(8'h80, 8'h80, 16'h4000, 9, 9, 1'b1, 1'b0);
        issue(8'h00, 8'hFF, 16'h0000, 9, 9, 1'b1, 1'b0);
        issue(8'hA5, 8'h03, 16'h01EF, 9, 4, 1'b1, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);

        chk("done_count", ndone, npush);
        chk("queue_empty", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
